mem_stage: RTL

Memory-access pipeline stage between execute and writeback. Latches the execute-stage bus, waits for the data-SRAM response of any memory request the execute stage issued, and aligns/extends load data. It also holds a returned word while writeback stalls and presents the 70-bit result bus to writeback. An optional forwarding bus reports the in-flight destination and result to decode.

---
 rtl/mem_stage.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage -- memory-access pipeline stage between execute and writeback.
//
// Latches the execute-stage bus. Waits for the data-SRAM response of a
// memory request, then aligns and extends the load data. If writeback
// stalls, the returned word is held in a buffer. The stage presents the
// 70-bit result bus to writeback.
//
// Optional feature macro: MS_FWD_EN
//   defined   : ms_to_ds_bus carries forwarding/interlock info to decode
//   undefined : ms_to_ds_bus is tied to zero and no forwarding logic is built
//
// Bus widths (normally supplied by mycpu.vh; defaults given here):
//   ES_TO_MS_BUS_WD 75 : {mem_req, res_from_mem, load_op[2:0], gr_we, dest[4:0],
//                         alu_result[31:0], pc[31:0]}
//   MS_TO_WS_BUS_WD 70 : {gr_we, dest[4:0], final_result[31:0], pc[31:0]}
//   MS_TO_DS_BUS_WD 40 : {fwd_valid, blocking, gr_we, dest[4:0], result[31:0]}
//
// Ports:
//   clk                in  : clock, rising edge
//   resetn             in  : asynchronous active-low reset
//   ms_allowin         out : stage can accept an instruction this cycle
//   es_to_ms_valid     in  : execute presents a valid instruction
//   es_to_ms_bus       in  : execute payload
//   ws_allowin         in  : writeback can accept
//   ms_to_ws_valid     out : completed instruction for writeback
//   ms_to_ws_bus       out : result payload
//   data_sram_data_ok  in  : one-cycle response pulse for the outstanding request
//   data_sram_rdata    in  : read data, valid with data_ok
//   ms_to_ds_bus       out : forwarding/interlock info to decode
//
// FSM states:
//   state    | meaning
//   ST_EMPTY | no instruction held
//   ST_WAIT  | memory request outstanding, waiting for data_ok
//   ST_DONE  | result ready (non-memory op, or load word held in rdata_buf_q)

`ifndef ES_TO_MS_BUS_WD
`define ES_TO_MS_BUS_WD 75
`endif
`ifndef MS_TO_WS_BUS_WD
`define MS_TO_WS_BUS_WD 70
`endif
`ifndef MS_TO_DS_BUS_WD
`define MS_TO_DS_BUS_WD 40
`endif

module mem_stage (
    input  logic                          clk,
    input  logic                          resetn,
    output logic                          ms_allowin,
    input  logic                          es_to_ms_valid,
    input  logic [`ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus,
    input  logic                          ws_allowin,
    output logic                          ms_to_ws_valid,
    output logic [`MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus,
    input  logic                          data_sram_data_ok,
    input  logic [31:0]                   data_sram_rdata,
    output logic [`MS_TO_DS_BUS_WD-1:0]   ms_to_ds_bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2
    } ms_state_e;

    ms_state_e                       state_q;
    logic                            ms_valid_q;
    logic [`ES_TO_MS_BUS_WD-1:0]     ms_bus_q;
    logic [31:0]                     rdata_buf_q;

    // Fields of the latched instruction (mem_req only matters at accept time).
    logic                            ms_res_from_mem;
    logic [2:0]                      ms_load_op;
    logic                            ms_gr_we;
    logic [4:0]                      ms_dest;
    logic [31:0]                     ms_alu_result;
    logic [31:0]                     ms_pc;

    assign ms_res_from_mem = ms_bus_q[73];
    assign ms_load_op      = ms_bus_q[72:70];
    assign ms_gr_we        = ms_bus_q[69];
    assign ms_dest         = ms_bus_q[68:64];
    assign ms_alu_result   = ms_bus_q[63:32];
    assign ms_pc           = ms_bus_q[31:0];

    logic                            es_mem_req;
    assign es_mem_req = es_to_ms_bus[74];

    logic ms_ready_go;
    logic accept;
    logic ws_take;
    ms_state_e accept_state;

    // In WAIT the response is passed straight through in the same cycle so a
    // load with an immediate data_ok costs only one cycle in the stage.
    always_comb begin
        ms_ready_go = 1'b0;
        case (state_q)
            ST_WAIT:  ms_ready_go = data_sram_data_ok;
            ST_DONE:  ms_ready_go = 1'b1;
            default:  ms_ready_go = 1'b0;
        endcase
    end

    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign accept         = es_to_ms_valid && ms_allowin;
    assign ws_take        = ms_valid_q && ms_ready_go && ws_allowin;
    assign accept_state   = es_mem_req ? ST_WAIT : ST_DONE;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_EMPTY;
            ms_valid_q  <= 1'b0;
            ms_bus_q    <= '0;
            rdata_buf_q <= '0;
        end else begin
            if (ms_allowin) begin
                ms_valid_q <= es_to_ms_valid;
            end
            if (accept) begin
                ms_bus_q <= es_to_ms_bus;
            end
            // Only a response in WAIT belongs to this stage; anything else is stray.
            if (state_q == ST_WAIT && data_sram_data_ok) begin
                rdata_buf_q <= data_sram_rdata;
            end

            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_q <= accept_state;
                    end
                end
                ST_WAIT: begin
                    if (data_sram_data_ok) begin
                        if (ws_take) begin
                            state_q <= accept ? accept_state : ST_EMPTY;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (ws_take) begin
                        state_q <= accept ? accept_state : ST_EMPTY;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    // Load data: live response while waiting, held buffer once done.
    logic [31:0] ld_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] mem_result;
    logic [31:0] final_result;

    assign ld_word = (state_q == ST_WAIT) ? data_sram_rdata : rdata_buf_q;

    always_comb begin
        ld_byte = ld_word[7:0];
        case (ms_alu_result[1:0])
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = ms_alu_result[1] ? ld_word[31:16] : ld_word[15:0];

        mem_result = ld_word;
        case (ms_load_op)
            3'b000:  mem_result = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  mem_result = {24'h000000, ld_byte};
            3'b001:  mem_result = {{16{ld_half[15]}}, ld_half};
            3'b101:  mem_result = {16'h0000, ld_half};
            default: mem_result = ld_word;
        endcase
    end

    assign final_result = ms_res_from_mem ? mem_result : ms_alu_result;
    assign ms_to_ws_bus = {ms_gr_we, ms_dest, final_result, ms_pc};

`ifdef MS_FWD_EN
    // Decode must stall on a load whose data has not returned yet.
    logic fwd_blocking;
    assign fwd_blocking = ms_valid_q && ms_res_from_mem && !ms_ready_go;
    assign ms_to_ds_bus = {ms_valid_q, fwd_blocking, ms_gr_we, ms_dest, final_result};
`else
    assign ms_to_ds_bus = '0;
`endif

endmodule
